// File: rtl/can_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit CAN transmit port among NREQ requesters.
// Optional hold timeout with drop pulse is enabled by defining CAN_TX_ARB_TIMEOUT_EN.
module can_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [32*NREQ-1:0]       req_data,
  output logic                     can_tx_valid,
  input  logic                     can_tx_ready,
  output logic [31:0]              can_tx_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     drop
);

  localparam int unsigned IDW = $clog2(NREQ);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic           any;
  logic           grant;
  logic           expire;

  // Pick the first valid requester after the last granted one, wrapping around.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    sel  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = int'(NREQ); k > 0; k--) begin
      cand = IDW'((int'(last) + k) % int'(NREQ));
      if (req_valid[cand]) begin
        sel = cand;
        any = 1'b1;
      end
    end
  end

  assign grant = (state == IDLE) && any;

  always_comb begin
    req_ready = '0;
    if (rstn && grant) begin
      req_ready[sel] = 1'b1;
    end
  end

`ifdef CAN_TX_ARB_TIMEOUT_EN
  logic [31:0] cnt;

  // Counts HOLD cycles; held at zero in IDLE so it starts from zero on each grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // A handshake in the expiry cycle takes precedence over the discard.
  assign expire = (state == HOLD) && (cnt == 32'(TIMEOUT - 1)) && !can_tx_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop <= 1'b0;
    end else begin
      drop <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign drop   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (can_tx_ready || expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted word; it stays untouched for the whole HOLD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      can_tx_data <= '0;
      grant_id    <= '0;
      last        <= IDW'(NREQ - 1);
    end else if (grant) begin
      can_tx_data <= req_data[32*sel +: 32];
      grant_id    <= sel;
      last        <= sel;
    end
  end

  assign can_tx_valid = (state == HOLD);
  assign busy         = (state == HOLD);

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed self-checking bench for can_tx_arbiter (NREQ=4).
// Timeout scenarios run only when CAN_TX_ARB_TIMEOUT_EN is defined.
module tb_can_tx_arbiter;

  localparam int unsigned NREQ = 4;
`ifdef CAN_TX_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 8;
  localparam int          STALL = 5;
`else
  localparam int unsigned TO    = 50000000;
  localparam int          STALL = 20;
`endif

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_data;
  logic                 can_tx_valid;
  logic                 can_tx_ready;
  logic [31:0]          can_tx_data;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 drop;

  int n_chk;
  int n_pass;

  can_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .can_tx_valid (can_tx_valid),
    .can_tx_ready (can_tx_ready),
    .can_tx_data  (can_tx_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .drop         (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs are driven here, checks follow a #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order_a [5];
    int order_b [3];
    n_chk  = 0;
    n_pass = 0;
    order_a = '{0, 1, 2, 3, 0};
    order_b = '{2, 0, 2};

    rstn         = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    can_tx_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(can_tx_valid), 32'd0);
    chk("rst_data",  can_tx_data,       32'd0);
    chk("rst_gid",   32'(grant_id),     32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_drop",  32'(drop),         32'd0);
    chk("rst_ready", 32'(req_ready),    32'd0);
    tick();
    tick();
    rstn = 1'b1;

    // Single word from requester 0.
    tick();
    req_valid         = 4'b0001;
    req_data[31:0]    = 32'h0000_00A5;
    can_tx_ready      = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_valid", 32'(can_tx_valid), 32'd1);
    chk("t1_data",  can_tx_data,       32'hA5);
    chk("t1_gid",   32'(grant_id),     32'd0);
    chk("t1_busy",  32'(busy),         32'd1);
    tick();
    #1;
    chk("t1_valid_off", 32'(can_tx_valid), 32'd0);
    chk("t1_busy_off",  32'(busy),         32'd0);

    // Stall in HOLD while the source word keeps changing.
    tick();
    req_valid       = 4'b0010;
    req_data[63:32] = 32'h0000_00B1;
    can_tx_ready    = 1'b0;
    #1;
    chk("t4_req_ready", 32'(req_ready), 32'h2);
    for (int i = 0; i < STALL; i++) begin
      tick();
      req_data[63:32] = $urandom;
      #1;
      chk("t4_hold_data",  can_tx_data,       32'hB1);
      chk("t4_hold_valid", 32'(can_tx_valid), 32'd1);
      chk("t4_hold_ready", 32'(req_ready),    32'd0);
      chk("t4_hold_drop",  32'(drop),         32'd0);
    end
    req_valid    = '0;
    can_tx_ready = 1'b1;
    tick();
    #1;
    chk("t4_release", 32'(can_tx_valid), 32'd0);
    chk("t4_gid",     32'(grant_id),     32'd1);

    // Reset asserted while a word is held.
    tick();
    req_valid        = 4'b0100;
    req_data[95:64]  = 32'h0000_00C2;
    can_tx_ready     = 1'b0;
    tick();
    req_valid = '0;
    #1;
    chk("t5_pre_valid", 32'(can_tx_valid), 32'd1);
    chk("t5_pre_data",  can_tx_data,       32'hC2);
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(can_tx_valid), 32'd0);
    chk("t5_rst_data",  can_tx_data,       32'd0);
    chk("t5_rst_gid",   32'(grant_id),     32'd0);
    tick();

    // Full round robin from reset: 0,1,2,3,0, one word every two cycles.
    rstn         = 1'b1;
    req_valid    = 4'b1111;
    can_tx_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h10 + 32'(i);
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("t2_req_ready", 32'(req_ready), 32'h1 << order_a[g]);
      tick();
      #1;
      chk("t2_valid", 32'(can_tx_valid), 32'd1);
      chk("t2_data",  can_tx_data,       32'h10 + 32'(order_a[g]));
      chk("t2_gid",   32'(grant_id),     32'(order_a[g]));
      chk("t2_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end

    // Sparse requesters 0 and 2 after last grant 0: 2,0,2.
    req_valid = 4'b0101;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("t3_req_ready", 32'(req_ready), 32'h1 << order_b[g]);
      tick();
      #1;
      chk("t3_data", can_tx_data,   32'h10 + 32'(order_b[g]));
      chk("t3_gid",  32'(grant_id), 32'(order_b[g]));
      tick();
    end

`ifdef CAN_TX_ARB_TIMEOUT_EN
    // Timeout discard: last=2, requesters 3 and 0 valid, controller never ready.
    req_valid    = 4'b1001;
    can_tx_ready = 1'b0;
    #1;
    chk("to_req_ready", 32'(req_ready), 32'h8);
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      chk("to_valid", 32'(can_tx_valid), 32'd1);
      chk("to_nodrop", 32'(drop),        32'd0);
    end
    tick();
    #1;
    chk("to_valid_off", 32'(can_tx_valid), 32'd0);
    chk("to_drop",      32'(drop),         32'd1);
    chk("to_gid_keep",  32'(grant_id),     32'd3);
    chk("to_next_req",  32'(req_ready),    32'h1);
    tick();
    #1;
    chk("to_drop_once", 32'(drop),         32'd0);
    chk("to_next_gid",  32'(grant_id),     32'd0);
    for (int c = 0; c < 7; c++) begin
      tick();
      #1;
      chk("to2_valid", 32'(can_tx_valid), 32'd1);
    end
    req_valid    = '0;
    can_tx_ready = 1'b1;
    tick();
    #1;
    chk("to2_valid_off", 32'(can_tx_valid), 32'd0);
    chk("to2_nodrop",    32'(drop),         32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
